// File: rtl/display_pkg.sv
// Shared types and default timing for the multiplexed seven-segment display.
// Default timing targets a 48 MHz HSOSC: about 1 kHz per digit, with a 1% blank gap.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } mux_state_t;

  localparam int HSOSC_HZ             = 48_000_000;
  localparam int DEFAULT_DWELL_CYCLES = HSOSC_HZ / 2000;
  localparam int DEFAULT_BLANK_CYCLES = DEFAULT_DWELL_CYCLES / 100;

endpackage

// File: rtl/display_mux_timer.sv
// Loadable down-counter that stops at zero.
// done is registered and reads high whenever the held count is zero.
module display_mux_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic             done_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg  <= '0;
      done_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_next;
      done_reg <= (cnt_next == '0);
    end
  end

  assign done = done_reg;

endmodule

// File: rtl/display_mux_scheduler.sv
// Scans NUM_DIGITS common-anode digits through one shared hex decoder.
// Define DISPLAY_MUX_BLANK_EN to insert an all-dark gap between digits.
module display_mux_scheduler
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digit_in,
  output logic [3:0]              hex_sel,
  output logic [NUM_DIGITS-1:0]   seg_power,
  output logic                    frame_tick
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  mux_state_t            state_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [IDX_W-1:0]      idx_next;
  logic [3:0]            hex_reg;
  logic [NUM_DIGITS-1:0] seg_reg;
  logic                  frame_reg;
  logic                  timer_load;
  logic [CNT_W-1:0]      timer_val;
  logic                  timer_done;
  logic [3:0]            digit_arr [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_arr[gi] = digit_in[4*gi +: 4];
  end

  assign idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);

  // The counter reloads on every state change so expiry always means "leave now".
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    if (enable) begin
      case (state_reg)
`ifdef DISPLAY_MUX_BLANK_EN
        IDLE: begin
          timer_load = 1'b1;
          timer_val  = CNT_W'(BLANK_CYCLES - 1);
        end
        BLANK: begin
          timer_load = timer_done;
          timer_val  = CNT_W'(DWELL_CYCLES - 1);
        end
        SHOW: begin
          timer_load = timer_done;
          timer_val  = CNT_W'(BLANK_CYCLES - 1);
        end
`else
        IDLE: begin
          timer_load = 1'b1;
          timer_val  = CNT_W'(DWELL_CYCLES - 1);
        end
        SHOW: begin
          timer_load = timer_done;
          timer_val  = CNT_W'(DWELL_CYCLES - 1);
        end
`endif
        default: begin
          timer_load = 1'b0;
          timer_val  = '0;
        end
      endcase
    end
  end

  display_mux_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .load_val(timer_val),
    .done    (timer_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      hex_reg   <= 4'h0;
      seg_reg   <= '1;
      frame_reg <= 1'b0;
    end else begin
      frame_reg <= 1'b0;
      if (!enable) begin
        state_reg <= IDLE;
        seg_reg   <= '1;
      end else begin
        case (state_reg)
`ifdef DISPLAY_MUX_BLANK_EN
          IDLE: begin
            state_reg <= BLANK;
            idx_reg   <= '0;
            seg_reg   <= '1;
          end
          BLANK: begin
            if (timer_done) begin
              state_reg <= SHOW;
              hex_reg   <= digit_arr[idx_reg];
              seg_reg   <= ~(NUM_DIGITS'(1) << idx_reg);
            end
          end
          SHOW: begin
            if (timer_done) begin
              state_reg <= BLANK;
              idx_reg   <= idx_next;
              seg_reg   <= '1;
              frame_reg <= (idx_reg == LAST_IDX);
            end
          end
`else
          IDLE: begin
            state_reg <= SHOW;
            idx_reg   <= '0;
            hex_reg   <= digit_arr[0];
            seg_reg   <= ~NUM_DIGITS'(1);
          end
          SHOW: begin
            if (timer_done) begin
              idx_reg   <= idx_next;
              hex_reg   <= digit_arr[idx_next];
              seg_reg   <= ~(NUM_DIGITS'(1) << idx_next);
              frame_reg <= (idx_reg == LAST_IDX);
            end
          end
`endif
          default: begin
            state_reg <= IDLE;
            seg_reg   <= '1;
          end
        endcase
      end
    end
  end

  assign hex_sel    = hex_reg;
  assign seg_power  = seg_reg;
  assign frame_tick = frame_reg;

endmodule

// File: tb/tb_display_mux_scheduler.sv
// Bench for display_mux_scheduler: directed scenarios plus random enable/reset/digit traffic,
// checked against a cycle-position model of the scan schedule.
module tb_display_mux_scheduler;

  localparam int N  = 2;
  localparam int DW = 4;
  localparam int BL = 2;
`ifdef DISPLAY_MUX_BLANK_EN
  localparam int B_EFF = BL;
`else
  localparam int B_EFF = 0;
`endif
  localparam int P     = B_EFF + DW;
  localparam int FRAME = N * P;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [4*N-1:0] digit_in = '0;
  logic [3:0]     hex_sel;
  logic [N-1:0]   seg_power;
  logic           frame_tick;

  int checks = 0;
  int failures = 0;

  // Model: m_c counts cycles since the scan (re)started; everything follows from it.
  bit         m_running = 1'b0;
  int         m_c = 0;
  logic [3:0] m_hex = 4'h0;

  display_mux_scheduler #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .digit_in  (digit_in),
    .hex_sel   (hex_sel),
    .seg_power (seg_power),
    .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  function automatic int exp_digit();
    return (m_c / P) % N;
  endfunction

  function automatic logic [N-1:0] exp_seg();
    if (!m_running || (m_c % P) < B_EFF) return '1;
    return ~(N'(1) << exp_digit());
  endfunction

  function automatic logic exp_frame();
    return m_running && (m_c > 0) && ((m_c % FRAME) == 0);
  endfunction

  task automatic tick();
    if (reset) begin
      m_running = 1'b0;
      m_hex = 4'h0;
    end else if (!enable) begin
      m_running = 1'b0;
    end else if (!m_running) begin
      m_running = 1'b1;
      m_c = 0;
    end else begin
      m_c++;
    end
    if (!reset && m_running && (m_c % P) == B_EFF) m_hex = digit_in[4*exp_digit() +: 4];
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    digit_in = 8'h51;
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("test_reset cyc=%0d seg=%b hex=%h frame=%b", i, seg_power, hex_sel, frame_tick);
      checks++;
      if (seg_power !== 2'b11) begin failures++; $display("FAIL reset_seg got=%b exp=11", seg_power); end
      checks++;
      if (hex_sel !== 4'h0) begin failures++; $display("FAIL reset_hex got=%h exp=0", hex_sel); end
      checks++;
      if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame_tick); end
    end
    reset = 1'b0;
  endtask

  task automatic test_normal_scan();
    enable = 1'b1;
    digit_in = 8'h51;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      tick();
      $display("test_normal_scan c=%0d seg=%b hex=%h frame=%b", m_c, seg_power, hex_sel, frame_tick);
      checks++;
      if (seg_power !== exp_seg()) begin failures++; $display("FAIL scan_seg c=%0d got=%b exp=%b", m_c, seg_power, exp_seg()); end
      checks++;
      if (hex_sel !== m_hex) begin failures++; $display("FAIL scan_hex c=%0d got=%h exp=%h", m_c, hex_sel, m_hex); end
      checks++;
      if (frame_tick !== exp_frame()) begin failures++; $display("FAIL scan_frame c=%0d got=%b exp=%b", m_c, frame_tick, exp_frame()); end
    end
  endtask

  task automatic test_value_stability();
    enable = 1'b0;
    tick();
    checks++;
    if (seg_power !== 2'b11) begin failures++; $display("FAIL stab_dark got=%b exp=11", seg_power); end
    enable = 1'b1;
    digit_in = 8'h51;
    for (int i = 0; i < 4 * FRAME && !(m_running && exp_digit() == 0 && (m_c % P) == B_EFF + 1); i++) begin
      tick();
      checks++;
      if (seg_power !== exp_seg()) begin failures++; $display("FAIL stab_seg c=%0d got=%b exp=%b", m_c, seg_power, exp_seg()); end
    end
    digit_in = 8'hAF;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      $display("test_value_stability c=%0d seg=%b hex=%h frame=%b", m_c, seg_power, hex_sel, frame_tick);
      checks++;
      if (seg_power !== exp_seg()) begin failures++; $display("FAIL stab_seg c=%0d got=%b exp=%b", m_c, seg_power, exp_seg()); end
      checks++;
      if (hex_sel !== m_hex) begin failures++; $display("FAIL stab_hex c=%0d got=%h exp=%h", m_c, hex_sel, m_hex); end
      checks++;
      if (frame_tick !== exp_frame()) begin failures++; $display("FAIL stab_frame c=%0d got=%b exp=%b", m_c, frame_tick, exp_frame()); end
    end
  endtask

  task automatic test_disable();
    enable = 1'b1;
    digit_in = 8'h3C;
    for (int i = 0; i < 4 * FRAME && !(m_running && (m_c % P) == B_EFF + 1); i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      $display("test_disable off cyc=%0d seg=%b hex=%h", i, seg_power, hex_sel);
      checks++;
      if (seg_power !== 2'b11) begin failures++; $display("FAIL disable_seg cyc=%0d got=%b exp=11", i, seg_power); end
      checks++;
      if (hex_sel !== m_hex) begin failures++; $display("FAIL disable_hex cyc=%0d got=%h exp=%h", i, hex_sel, m_hex); end
    end
    enable = 1'b1;
    for (int i = 0; i < FRAME + 1; i++) begin
      tick();
      $display("test_disable on c=%0d seg=%b hex=%h frame=%b", m_c, seg_power, hex_sel, frame_tick);
      checks++;
      if (seg_power !== exp_seg()) begin failures++; $display("FAIL reenable_seg c=%0d got=%b exp=%b", m_c, seg_power, exp_seg()); end
      checks++;
      if (hex_sel !== m_hex) begin failures++; $display("FAIL reenable_hex c=%0d got=%h exp=%h", m_c, hex_sel, m_hex); end
      checks++;
      if (frame_tick !== exp_frame()) begin failures++; $display("FAIL reenable_frame c=%0d got=%b exp=%b", m_c, frame_tick, exp_frame()); end
    end
  endtask

  task automatic test_reset_mid_show();
    enable = 1'b1;
    digit_in = 8'h97;
    for (int i = 0; i < 4 * FRAME && !(m_running && exp_digit() == 1 && (m_c % P) >= B_EFF); i++) tick();
    reset = 1'b1;
    tick();
    $display("test_reset_mid_show rst seg=%b hex=%h frame=%b", seg_power, hex_sel, frame_tick);
    checks++;
    if (seg_power !== 2'b11) begin failures++; $display("FAIL midrst_seg got=%b exp=11", seg_power); end
    checks++;
    if (hex_sel !== 4'h0) begin failures++; $display("FAIL midrst_hex got=%h exp=0", hex_sel); end
    reset = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      $display("test_reset_mid_show c=%0d seg=%b hex=%h frame=%b", m_c, seg_power, hex_sel, frame_tick);
      checks++;
      if (seg_power !== exp_seg()) begin failures++; $display("FAIL midrst_seg c=%0d got=%b exp=%b", m_c, seg_power, exp_seg()); end
      checks++;
      if (hex_sel !== m_hex) begin failures++; $display("FAIL midrst_hex c=%0d got=%h exp=%h", m_c, hex_sel, m_hex); end
      checks++;
      if (frame_tick !== exp_frame()) begin failures++; $display("FAIL midrst_frame c=%0d got=%b exp=%b", m_c, frame_tick, exp_frame()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 7) == 0) digit_in = 8'($urandom);
      tick();
      checks++;
      if (seg_power !== exp_seg()) begin failures++; $display("FAIL rand_seg i=%0d got=%b exp=%b", i, seg_power, exp_seg()); end
      checks++;
      if (hex_sel !== m_hex) begin failures++; $display("FAIL rand_hex i=%0d got=%h exp=%h", i, hex_sel, m_hex); end
      checks++;
      if (frame_tick !== exp_frame()) begin failures++; $display("FAIL rand_frame i=%0d got=%b exp=%b", i, frame_tick, exp_frame()); end
    end
    reset = 1'b0;
    $display("test_random done checks=%0d", checks);
  endtask

  initial begin
    test_reset();
    test_normal_scan();
    test_value_stability();
    test_disable();
    test_reset_mid_show();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
